// File: rtl/demux_1x32_to_2x32_pkg.sv
// Shared constants for the 1-to-2 stream demultiplexer.
// Channel select encoding, default data width and word-count width.
package demux_1x32_to_2x32_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int CNT_WIDTH  = 16;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/demux_out_buf.sv
// Two-entry output FIFO for one demux channel.
// Head entry is driven straight from storage so the output is registered.
module demux_out_buf
    import demux_1x32_to_2x32_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             valid,
    output logic [WIDTH-1:0] head_data,
    output logic             full
);

    logic [WIDTH-1:0] mem [2];
    logic             head;
    logic             tail;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign valid     = (count != 2'd0);
    assign full      = (count == 2'(DEPTH));
    assign head_data = mem[head];
    assign do_pop    = valid && pop_ready;
    // A full buffer refuses a push even when it pops in the same cycle.
    assign do_push   = push && !full;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            head   <= 1'b0;
            tail   <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[tail] <= push_data;
                tail      <= ~tail;
            end
            if (do_pop) begin
                head <= ~head;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/demux_1x32_to_2x32.sv
// Registered 1-to-2 stream demux with a 2-entry buffer per channel.
// Define DEMUX_WORD_COUNT_EN to add per-channel 16-bit accepted-word counters.
module demux_1x32_to_2x32 #(
    parameter int DATA_WIDTH = demux_1x32_to_2x32_pkg::DATA_WIDTH,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] DataIn,
    input  logic                  Select,
    input  logic                  InValid,
    output logic                  InReady,
    output logic [DATA_WIDTH-1:0] DataOutA,
    output logic                  ValidA,
    input  logic                  ReadyA,
    output logic [DATA_WIDTH-1:0] DataOutB,
    output logic                  ValidB,
    input  logic                  ReadyB
`ifdef DEMUX_WORD_COUNT_EN
    ,
    output logic [demux_1x32_to_2x32_pkg::CNT_WIDTH-1:0] CountOutA,
    output logic [demux_1x32_to_2x32_pkg::CNT_WIDTH-1:0] CountOutB
`endif
);

    import demux_1x32_to_2x32_pkg::*;

    logic full_a;
    logic full_b;
    logic push_a;
    logic push_b;

    // Ready looks only at registered fullness, never at the consumers.
    assign InReady = (Select == SEL_B) ? !full_b : !full_a;
    assign push_a  = InValid && InReady && (Select == SEL_A);
    assign push_b  = InValid && InReady && (Select == SEL_B);

    demux_out_buf #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf_a (
        .clk       (Clock),
        .rst       (Reset),
        .push      (push_a),
        .push_data (DataIn),
        .pop_ready (ReadyA),
        .valid     (ValidA),
        .head_data (DataOutA),
        .full      (full_a)
    );

    demux_out_buf #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf_b (
        .clk       (Clock),
        .rst       (Reset),
        .push      (push_b),
        .push_data (DataIn),
        .pop_ready (ReadyB),
        .valid     (ValidB),
        .head_data (DataOutB),
        .full      (full_b)
    );

`ifdef DEMUX_WORD_COUNT_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            CountOutA <= '0;
            CountOutB <= '0;
        end else begin
            if (push_a) CountOutA <= CountOutA + 1'b1;
            if (push_b) CountOutB <= CountOutB + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_demux_1x32_to_2x32.sv
// Bench for demux_1x32_to_2x32: queue-based channel model plus directed tests.
// Word counters are checked when DEMUX_WORD_COUNT_EN is defined.
module tb_demux_1x32_to_2x32;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] DataIn;
    logic        Select;
    logic        InValid;
    logic        InReady;
    logic [31:0] DataOutA;
    logic        ValidA;
    logic        ReadyA;
    logic [31:0] DataOutB;
    logic        ValidB;
    logic        ReadyB;
`ifdef DEMUX_WORD_COUNT_EN
    logic [15:0] CountOutA;
    logic [15:0] CountOutB;
`endif

    demux_1x32_to_2x32 dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .DataIn   (DataIn),
        .Select   (Select),
        .InValid  (InValid),
        .InReady  (InReady),
        .DataOutA (DataOutA),
        .ValidA   (ValidA),
        .ReadyA   (ReadyA),
        .DataOutB (DataOutB),
        .ValidB   (ValidB),
        .ReadyB   (ReadyB)
`ifdef DEMUX_WORD_COUNT_EN
        ,
        .CountOutA (CountOutA),
        .CountOutB (CountOutB)
`endif
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: each channel is a queue of at most two words.
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [15:0] mca = 16'd0;
    logic [15:0] mcb = 16'd0;
    bit          model_on = 1'b0;

    // Words observed leaving the DUT, in order.
    logic [31:0] loga[$];
    logic [31:0] logb[$];

    always @(posedge Clock) begin
        if (Reset) begin
            qa.delete();
            qb.delete();
            mca = 16'd0;
            mcb = 16'd0;
            model_on = 1'b1;
        end else if (model_on) begin
            bit acc;
            acc = InValid && ((Select ? qb.size() : qa.size()) != 2);
            if (ReadyA && qa.size() > 0) void'(qa.pop_front());
            if (ReadyB && qb.size() > 0) void'(qb.pop_front());
            if (acc) begin
                if (Select) begin
                    qb.push_back(DataIn);
                    mcb = mcb + 16'd1;
                end else begin
                    qa.push_back(DataIn);
                    mca = mca + 16'd1;
                end
            end
        end
    end

    always @(negedge Clock) begin
        if (model_on) begin
            chk("valid_a", 32'(ValidA), 32'(qa.size() != 0));
            chk("valid_b", 32'(ValidB), 32'(qb.size() != 0));
            if (qa.size() != 0) chk("data_a", DataOutA, qa[0]);
            if (qb.size() != 0) chk("data_b", DataOutB, qb[0]);
            chk("in_ready", 32'(InReady),
                32'((Select ? qb.size() : qa.size()) != 2));
`ifdef DEMUX_WORD_COUNT_EN
            chk("count_a", 32'(CountOutA), 32'(mca));
            chk("count_b", 32'(CountOutB), 32'(mcb));
`endif
            if (!Reset && ValidA && ReadyA) loga.push_back(DataOutA);
            if (!Reset && ValidB && ReadyB) logb.push_back(DataOutB);
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic send(logic sel, logic [31:0] d, output int stalls);
        bit seen;
        Select  = sel;
        DataIn  = d;
        InValid = 1'b1;
        stalls  = 0;
        seen    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            if (InReady) begin
                seen = 1'b1;
                break;
            end
            stalls++;
        end
        chk("send_accept", 32'(seen), 32'd1);
        @(posedge Clock);
        #1;
        InValid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    initial begin
        int st;
        int tot;
        int bad;

        Reset   = 1'b1;
        InValid = 1'b1;
        DataIn  = 32'hDEADBEEF;
        Select  = 1'b0;
        ReadyA  = 1'b0;
        ReadyB  = 1'b0;

        // Reset with a word offered: nothing may be accepted
        tick(2);
        chk("rst_valid_a", 32'(ValidA), 32'd0);
        chk("rst_valid_b", 32'(ValidB), 32'd0);
        chk("rst_data_a", DataOutA, 32'd0);
        chk("rst_data_b", DataOutB, 32'd0);
        Reset   = 1'b0;
        InValid = 1'b0;
        #1;
        chk("rst_in_ready", 32'(InReady), 32'd1);
        tick(1);
        chk("rst_nothing_a", 32'(ValidA), 32'd0);

        // Single route to A then B
        ReadyA = 1'b1;
        ReadyB = 1'b1;
        send(1'b0, 32'h12345678, st);
        chk("route_a_valid", 32'(ValidA), 32'd1);
        chk("route_a_data", DataOutA, 32'h12345678);
        chk("route_a_b_idle", 32'(ValidB), 32'd0);
        send(1'b1, 32'h9ABCDEF0, st);
        chk("route_b_valid", 32'(ValidB), 32'd1);
        chk("route_b_data", DataOutB, 32'h9ABCDEF0);
        chk("route_b_a_idle", 32'(ValidA), 32'd0);
        tick(2);

        // Backpressure on A
        loga.delete();
        logb.delete();
        ReadyA = 1'b0;
        send(1'b0, 32'h1, st);
        send(1'b0, 32'h2, st);
        Select  = 1'b0;
        DataIn  = 32'h3;
        InValid = 1'b1;
        #1;
        chk("bp_stall", 32'(InReady), 32'd0);
        ReadyA = 1'b1;
        send(1'b0, 32'h3, st);
        chk("bp_stall_cycles", 32'(st), 32'd1);
        tick(4);
        chk("bp_log_size", 32'(loga.size()), 32'd3);
        if (loga.size() == 3) begin
            chk("bp_order0", loga[0], 32'h1);
            chk("bp_order1", loga[1], 32'h2);
            chk("bp_order2", loga[2], 32'h3);
        end

        // Channel isolation: A full, stream to B
        ReadyA = 1'b0;
        send(1'b0, 32'h11, st);
        send(1'b0, 32'h22, st);
        loga.delete();
        logb.delete();
        tot = 0;
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 32'hA0 + 32'(i), st);
            tot += st;
        end
        chk("iso_stalls", 32'(tot), 32'd0);
        Select = 1'b0;
        #1;
        chk("iso_a_full", 32'(InReady), 32'd0);
        tick(2);
        chk("iso_log_b", 32'(logb.size()), 32'd8);
        chk("iso_log_a", 32'(loga.size()), 32'd0);
        bad = 0;
        for (int i = 0; i < logb.size(); i++)
            if (logb[i] !== 32'hA0 + 32'(i)) bad++;
        chk("iso_order", 32'(bad), 32'd0);

        // Full throughput, alternating channels
        ReadyA = 1'b1;
        tick(3);
        loga.delete();
        logb.delete();
        tot = 0;
        for (int i = 0; i < 100; i++) begin
            send(1'(i % 2), 32'h1000 + 32'(i), st);
            tot += st;
        end
        tick(3);
        chk("tp_stalls", 32'(tot), 32'd0);
        chk("tp_size_a", 32'(loga.size()), 32'd50);
        chk("tp_size_b", 32'(logb.size()), 32'd50);
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            if (k < loga.size() && loga[k] !== 32'h1000 + 32'(2 * k)) bad++;
            if (k < logb.size() && logb[k] !== 32'h1001 + 32'(2 * k)) bad++;
        end
        chk("tp_order", 32'(bad), 32'd0);

        // Reset with both buffers full
        ReadyA = 1'b0;
        ReadyB = 1'b0;
        send(1'b0, 32'h61, st);
        send(1'b0, 32'h62, st);
        send(1'b1, 32'h63, st);
        send(1'b1, 32'h64, st);
        chk("mid_full_a", 32'(ValidA), 32'd1);
        chk("mid_full_b", 32'(ValidB), 32'd1);
        Reset   = 1'b1;
        InValid = 1'b1;
        Select  = 1'b0;
        DataIn  = 32'h99;
        tick(1);
        chk("mid_rst_valid_a", 32'(ValidA), 32'd0);
        chk("mid_rst_valid_b", 32'(ValidB), 32'd0);
`ifdef DEMUX_WORD_COUNT_EN
        chk("mid_rst_cnt_a", 32'(CountOutA), 32'd0);
        chk("mid_rst_cnt_b", 32'(CountOutB), 32'd0);
`endif
        Reset   = 1'b0;
        InValid = 1'b0;
        ReadyA  = 1'b1;
        ReadyB  = 1'b1;
        loga.delete();
        logb.delete();
        tick(4);
        chk("mid_no_old_a", 32'(loga.size()), 32'd0);
        chk("mid_no_old_b", 32'(logb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
